// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//
// Shares one single-port, request/acknowledge memory between the core's
// instruction-fetch port and its data port. One memory transaction is in
// flight at a time. A completion pulse goes back to the port that owned the
// transaction, and a watchdog aborts transactions that are never
// acknowledged.
//
// Transaction flow: IDLE (arbitrate and latch) -> BUSY (mem_req high) -> RESP
// (one-cycle done pulse) -> IDLE.
//
// Ports
//   clk        in   rising-edge clock
//   reset      in   asynchronous, active-low reset
//   if_req     in   fetch request, held until if_done
//   if_addr    in   [31:0] fetch address
//   if_rdata   out  [31:0] last successfully fetched word
//   if_done    out  fetch completion pulse (one cycle)
//   dm_req     in   data request, held until dm_done
//   dm_rd_wr   in   1 = read, 0 = write
//   dm_addr    in   [31:0] data address
//   dm_wdata   in   [31:0] data write value
//   dm_rdata   out  [31:0] last successfully read data word
//   dm_done    out  data completion pulse (one cycle)
//   err        out  qualifies the done pulses; 1 = the transaction timed out
//   mem_req    out  memory request, high throughout BUSY
//   mem_rd_wr  out  1 = read, 0 = write
//   mem_addr   out  [31:0] memory address
//   mem_wdata  out  [31:0] memory write data
//   mem_rdata  in   [31:0] memory read data, valid with mem_ack
//   mem_ack    in   one-cycle memory completion
//   owner      out  current or last grantee: 0 = fetch, 1 = data
//
// Parameter
//   TIMEOUT_CYCLES  BUSY cycles allowed without mem_ack (0 disables watchdog)
//
// Build option
//   MEM_ARB_DATA_PRIORITY_EN  when defined, a data request always beats a
//                             fetch request. Otherwise contention is resolved
//                             round-robin.
// -----------------------------------------------------------------------------
module mem_arbiter #(
    parameter logic [7:0] TIMEOUT_CYCLES = 8'd255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_done,
    input  logic        dm_req,
    input  logic        dm_rd_wr,
    input  logic [31:0] dm_addr,
    input  logic [31:0] dm_wdata,
    output logic [31:0] dm_rdata,
    output logic        dm_done,
    output logic        err,
    output logic        mem_req,
    output logic        mem_rd_wr,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    output logic        owner
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;

    logic        r_mem_req;
    logic        r_mem_rd_wr;
    logic [31:0] r_mem_addr;
    logic [31:0] r_mem_wdata;
    logic [31:0] r_if_rdata;
    logic [31:0] r_dm_rdata;
    logic        r_if_done;
    logic        r_dm_done;
    logic        r_err;
    logic        r_owner;
    logic [7:0]  r_wdog;

    logic        w_any_req;
    logic        w_pick_data;
    logic        w_timeout;
    logic        w_grant;
    logic        w_finish;

    logic        w_mem_req_nxt;
    logic        w_mem_rd_wr_nxt;
    logic [31:0] w_mem_addr_nxt;
    logic [31:0] w_mem_wdata_nxt;
    logic [31:0] w_if_rdata_nxt;
    logic [31:0] w_dm_rdata_nxt;
    logic        w_if_done_nxt;
    logic        w_dm_done_nxt;
    logic        w_err_nxt;
    logic        w_owner_nxt;
    logic [7:0]  w_wdog_nxt;

    assign w_any_req = if_req | dm_req;

    // Watchdog expiry: limit reached with no ack this cycle (an ack in the
    // expiry cycle takes precedence and completes normally).
    assign w_timeout = (TIMEOUT_CYCLES != 8'd0) && (r_wdog == TIMEOUT_CYCLES) && !mem_ack;

    // Arbitration winner for an IDLE cycle with at least one request.
    always_comb begin
        w_pick_data = 1'b0;
`ifdef MEM_ARB_DATA_PRIORITY_EN
        w_pick_data = dm_req;
`else
        if (if_req && dm_req) begin
            // r_owner holds the last grantee, so the other port wins.
            w_pick_data = ~r_owner;
        end else begin
            w_pick_data = dm_req;
        end
`endif
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_any_req) begin
                    w_state_nxt = ST_BUSY;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (mem_ack || w_timeout) begin
                    w_state_nxt = ST_RESP;
                end else begin
                    w_state_nxt = ST_BUSY;
                end
            end
            ST_RESP: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign w_grant  = (r_state == ST_IDLE) && w_any_req;
    assign w_finish = (r_state == ST_BUSY) && (mem_ack || w_timeout);

    // Output logic: next values of the registered outputs and watchdog.
    always_comb begin
        w_mem_req_nxt   = (w_state_nxt == ST_BUSY);
        w_mem_rd_wr_nxt = r_mem_rd_wr;
        w_mem_addr_nxt  = r_mem_addr;
        w_mem_wdata_nxt = r_mem_wdata;
        w_owner_nxt     = r_owner;
        w_if_rdata_nxt  = r_if_rdata;
        w_dm_rdata_nxt  = r_dm_rdata;
        w_if_done_nxt   = w_finish && !r_owner;
        w_dm_done_nxt   = w_finish && r_owner;
        w_wdog_nxt      = r_wdog;

        // err only rides along with the done pulse.
        if (r_state == ST_BUSY) begin
            w_err_nxt = w_timeout;
        end else begin
            w_err_nxt = 1'b0;
        end

        if (w_grant) begin
            w_owner_nxt = w_pick_data;
            w_wdog_nxt  = 8'd0;
            if (w_pick_data) begin
                w_mem_rd_wr_nxt = dm_rd_wr;
                w_mem_addr_nxt  = dm_addr;
                w_mem_wdata_nxt = dm_wdata;
            end else begin
                // Fetch is always a read; write data is left as it was.
                w_mem_rd_wr_nxt = 1'b1;
                w_mem_addr_nxt  = if_addr;
            end
        end else begin
            w_owner_nxt = r_owner;
        end

        if ((r_state == ST_BUSY) && mem_ack) begin
            if (!r_owner) begin
                w_if_rdata_nxt = mem_rdata;
            end else if (r_mem_rd_wr) begin
                w_dm_rdata_nxt = mem_rdata;
            end else begin
                w_dm_rdata_nxt = r_dm_rdata;
            end
        end else begin
            w_if_rdata_nxt = r_if_rdata;
        end

        // Saturate so a disabled watchdog never wraps.
        if ((r_state == ST_BUSY) && !mem_ack && !w_timeout && (r_wdog != 8'hFF)) begin
            w_wdog_nxt = r_wdog + 8'd1;
        end else begin
            w_wdog_nxt = w_grant ? 8'd0 : r_wdog;
        end
    end

    // Output and datapath registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_mem_req   <= 1'b0;
            r_mem_rd_wr <= 1'b1;
            r_mem_addr  <= 32'h0000_0000;
            r_mem_wdata <= 32'h0000_0000;
            r_if_rdata  <= 32'h0000_0000;
            r_dm_rdata  <= 32'h0000_0000;
            r_if_done   <= 1'b0;
            r_dm_done   <= 1'b0;
            r_err       <= 1'b0;
            r_owner     <= 1'b1;
            r_wdog      <= 8'd0;
        end else begin
            r_mem_req   <= w_mem_req_nxt;
            r_mem_rd_wr <= w_mem_rd_wr_nxt;
            r_mem_addr  <= w_mem_addr_nxt;
            r_mem_wdata <= w_mem_wdata_nxt;
            r_if_rdata  <= w_if_rdata_nxt;
            r_dm_rdata  <= w_dm_rdata_nxt;
            r_if_done   <= w_if_done_nxt;
            r_dm_done   <= w_dm_done_nxt;
            r_err       <= w_err_nxt;
            r_owner     <= w_owner_nxt;
            r_wdog      <= w_wdog_nxt;
        end
    end

    assign mem_req   = r_mem_req;
    assign mem_rd_wr = r_mem_rd_wr;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign if_rdata  = r_if_rdata;
    assign dm_rdata  = r_dm_rdata;
    assign if_done   = r_if_done;
    assign dm_done   = r_dm_done;
    assign err       = r_err;
    assign owner     = r_owner;

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter: directed, self-checking bench for mem_arbiter built with a
// 4-cycle watchdog. Inputs change 1 ns after a rising edge; registered outputs
// are observed at that same point, i.e. they show the state of the cycle
// that has just begun.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;

    logic        clk;
    logic        reset;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_done;
    logic        dm_req;
    logic        dm_rd_wr;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic [31:0] dm_rdata;
    logic        dm_done;
    logic        err;
    logic        mem_req;
    logic        mem_rd_wr;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    logic        owner;

    int checks;
    int failures;

    mem_arbiter #(.TIMEOUT_CYCLES(8'd4)) dut (
        .clk       (clk),
        .reset     (reset),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_rdata  (if_rdata),
        .if_done   (if_done),
        .dm_req    (dm_req),
        .dm_rd_wr  (dm_rd_wr),
        .dm_addr   (dm_addr),
        .dm_wdata  (dm_wdata),
        .dm_rdata  (dm_rdata),
        .dm_done   (dm_done),
        .err       (err),
        .mem_req   (mem_req),
        .mem_rd_wr (mem_rd_wr),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack),
        .owner     (owner)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    logic        exp_own;
    logic [31:0] rd_val;

    initial begin
        checks    = 0;
        failures  = 0;
        reset     = 1'b0;
        if_req    = 1'b0;
        if_addr   = 32'h0;
        dm_req    = 1'b0;
        dm_rd_wr  = 1'b1;
        dm_addr   = 32'h0;
        dm_wdata  = 32'h0;
        mem_rdata = 32'h0;
        mem_ack   = 1'b0;

        // Reset values
        tick();
        tick();
        check("rst_mem_req",   {31'd0, mem_req},   32'd0);
        check("rst_mem_rd_wr", {31'd0, mem_rd_wr}, 32'd1);
        check("rst_owner",     {31'd0, owner},     32'd1);
        check("rst_err",       {31'd0, err},       32'd0);
        check("rst_if_done",   {31'd0, if_done},   32'd0);
        check("rst_dm_done",   {31'd0, dm_done},   32'd0);
        check("rst_mem_addr",  mem_addr,           32'h0);
        check("rst_mem_wdata", mem_wdata,          32'h0);
        check("rst_if_rdata",  if_rdata,           32'h0);
        check("rst_dm_rdata",  dm_rdata,           32'h0);
        reset = 1'b1;
        tick();

        // Fetch read, ack two cycles after mem_req rises
        if_req  = 1'b1;
        if_addr = 32'h0000_0100;
        tick();
        check("f_mem_req",   {31'd0, mem_req},   32'd1);
        check("f_mem_addr",  mem_addr,           32'h0000_0100);
        check("f_mem_rd_wr", {31'd0, mem_rd_wr}, 32'd1);
        check("f_owner",     {31'd0, owner},     32'd0);
        check("f_done_b1",   {31'd0, if_done},   32'd0);
        tick();
        check("f_mem_req2",  {31'd0, mem_req},   32'd1);
        check("f_done_b2",   {31'd0, if_done},   32'd0);
        tick();
        check("f_mem_req3",  {31'd0, mem_req},   32'd1);
        mem_ack   = 1'b1;
        mem_rdata = 32'h2402_000A;
        tick();
        check("f_if_done",   {31'd0, if_done},   32'd1);
        check("f_err",       {31'd0, err},       32'd0);
        check("f_if_rdata",  if_rdata,           32'h2402_000A);
        check("f_mem_req_r", {31'd0, mem_req},   32'd0);
        check("f_dm_done",   {31'd0, dm_done},   32'd0);
        mem_ack   = 1'b0;
        mem_rdata = 32'h5555_5555;
        if_req    = 1'b0;
        tick();
        check("f_done_i1",   {31'd0, if_done},   32'd0);
        tick();
        check("f_done_i2",   {31'd0, if_done},   32'd0);
        check("f_rdata_hold", if_rdata,          32'h2402_000A);

        // Data write, zero-wait ack
        dm_req    = 1'b1;
        dm_rd_wr  = 1'b0;
        dm_addr   = 32'h0000_2000;
        dm_wdata  = 32'hDEAD_BEEF;
        mem_rdata = 32'h1234_5678;
        tick();
        check("w_mem_req",   {31'd0, mem_req},   32'd1);
        check("w_mem_rd_wr", {31'd0, mem_rd_wr}, 32'd0);
        check("w_mem_wdata", mem_wdata,          32'hDEAD_BEEF);
        check("w_mem_addr",  mem_addr,           32'h0000_2000);
        check("w_owner",     {31'd0, owner},     32'd1);
        mem_ack = 1'b1;
        tick();
        check("w_dm_done",   {31'd0, dm_done},   32'd1);
        check("w_err",       {31'd0, err},       32'd0);
        check("w_dm_rdata",  dm_rdata,           32'h0);
        check("w_if_done",   {31'd0, if_done},   32'd0);
        mem_ack = 1'b0;
        dm_req  = 1'b0;
        tick();

        // Timeout: no ack, watchdog limit 4
        dm_req    = 1'b1;
        dm_rd_wr  = 1'b1;
        dm_addr   = 32'h0000_3000;
        dm_wdata  = 32'h0BAD_0BAD;
        mem_rdata = 32'h0000_0BAD;
        tick();
        for (int i = 0; i < 5; i++) begin
            check("t_mem_req",  {31'd0, mem_req},  32'd1);
            check("t_no_done",  {31'd0, dm_done},  32'd0);
            tick();
        end
        check("t_dm_done",   {31'd0, dm_done},   32'd1);
        check("t_err",       {31'd0, err},       32'd1);
        check("t_mem_req_r", {31'd0, mem_req},   32'd0);
        check("t_dm_rdata",  dm_rdata,           32'h0);
        dm_req = 1'b0;
        tick();
        check("t_err_clr",   {31'd0, err},       32'd0);
        check("t_done_clr",  {31'd0, dm_done},   32'd0);

        // Ack in the expiry cycle wins
        dm_req  = 1'b1;
        dm_addr = 32'h0000_3004;
        tick();
        repeat (4) tick();
        check("e_mem_req",   {31'd0, mem_req},   32'd1);
        mem_ack   = 1'b1;
        mem_rdata = 32'hCAFE_F00D;
        tick();
        check("e_dm_done",   {31'd0, dm_done},   32'd1);
        check("e_err",       {31'd0, err},       32'd0);
        check("e_dm_rdata",  dm_rdata,           32'hCAFE_F00D);
        mem_ack = 1'b0;
        dm_req  = 1'b0;
        tick();

        // Both ports held, zero-wait ack (ack held; ignored outside BUSY)
        if_req   = 1'b1;
        if_addr  = 32'h0000_0200;
        dm_req   = 1'b1;
        dm_rd_wr = 1'b1;
        dm_addr  = 32'h0000_4000;
        mem_ack  = 1'b1;
        for (int g = 0; g < 4; g++) begin
`ifdef MEM_ARB_DATA_PRIORITY_EN
            exp_own = 1'b1;
`else
            exp_own = (g % 2 == 1);
`endif
            rd_val    = 32'hA000_0000 + 32'(g);
            mem_rdata = rd_val;
            tick();
            check("rr_owner",    {31'd0, owner},   {31'd0, exp_own});
            check("rr_mem_addr", mem_addr,         exp_own ? 32'h0000_4000 : 32'h0000_0200);
            tick();
            check("rr_if_done",  {31'd0, if_done}, {31'd0, ~exp_own});
            check("rr_dm_done",  {31'd0, dm_done}, {31'd0, exp_own});
            check("rr_rdata",    exp_own ? dm_rdata : if_rdata, rd_val);
            tick();
            check("rr_idle",     {31'd0, mem_req}, 32'd0);
        end

        // Reset mid-BUSY, both requests pending
        mem_ack = 1'b0;
        if_addr = 32'h0000_0400;
        dm_addr = 32'h0000_0500;
        tick();
        check("r_busy",      {31'd0, mem_req},   32'd1);
`ifdef MEM_ARB_DATA_PRIORITY_EN
        check("r_pre_owner", {31'd0, owner},     32'd1);
`else
        check("r_pre_owner", {31'd0, owner},     32'd0);
`endif
        reset = 1'b0;
        #1;
        check("r_req_drop",  {31'd0, mem_req},   32'd0);
        check("r_owner_rst", {31'd0, owner},     32'd1);
        tick();
        tick();
        check("r_no_if_done", {31'd0, if_done},  32'd0);
        check("r_no_dm_done", {31'd0, dm_done},  32'd0);
        reset = 1'b1;
        tick();
        check("r_regrant",   {31'd0, mem_req},   32'd1);
`ifdef MEM_ARB_DATA_PRIORITY_EN
        check("r_new_owner", {31'd0, owner},     32'd1);
        check("r_new_addr",  mem_addr,           32'h0000_0500);
`else
        check("r_new_owner", {31'd0, owner},     32'd0);
        check("r_new_addr",  mem_addr,           32'h0000_0400);
`endif
        mem_ack   = 1'b1;
        mem_rdata = 32'h7777_0001;
        tick();
`ifdef MEM_ARB_DATA_PRIORITY_EN
        check("r_done",      {31'd0, dm_done},   32'd1);
`else
        check("r_done",      {31'd0, if_done},   32'd1);
`endif
        check("r_err",       {31'd0, err},       32'd0);
        mem_ack = 1'b0;
        if_req  = 1'b0;
        dm_req  = 1'b0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
